// File: rtl/score_disp_pkg.sv
// Shared constants for the scoreboard seven-segment scan driver:
// active-low glyphs, anode patterns, glyph ROM codes and winner codes.
package score_disp_pkg;

    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_P     = 7'b0001100;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_DASH  = 4'd8;
    localparam logic [3:0] CODE_P     = 4'd9;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    localparam logic [3:0] AN_D0  = 4'b1110;
    localparam logic [3:0] AN_D1  = 4'b1101;
    localparam logic [3:0] AN_D2  = 4'b1011;
    localparam logic [3:0] AN_D3  = 4'b0111;
    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_e;

endpackage

// File: rtl/score_scan_display_if.sv
// Bundle between the game logic (master: drives scores) and the
// scan driver (slave: drives the display and winner flag).
interface score_scan_display_if;
    logic [2:0] score1;
    logic [2:0] score2;
    logic [6:0] seg;
    logic [3:0] an;
    logic [1:0] winner;

    modport master (output score1, output score2, input seg, input an, input winner);
    modport slave  (input score1, input score2, output seg, output an, output winner);
endinterface

// File: rtl/seg7_glyph_rom.sv
// Combinational glyph ROM: 4-bit code to active-low {g..a}.
// Codes 0-7 are digits, 8 is a dash, 9 is 'P', anything else is blank.
module seg7_glyph_rom
    import score_disp_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = GLYPH_BLANK;
        case (i_code)
            4'd0:      o_seg = GLYPH_0;
            4'd1:      o_seg = GLYPH_1;
            4'd2:      o_seg = GLYPH_2;
            4'd3:      o_seg = GLYPH_3;
            4'd4:      o_seg = GLYPH_4;
            4'd5:      o_seg = GLYPH_5;
            4'd6:      o_seg = GLYPH_6;
            4'd7:      o_seg = GLYPH_7;
            CODE_DASH: o_seg = GLYPH_DASH;
            CODE_P:    o_seg = GLYPH_P;
            default:   o_seg = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/score_scan_display.sv
// Four-digit scan driver for the scoreboard: frame-sampled scores, blink on
// every score change and a sticky winner banner, one digit per myClk cycle.
module score_scan_display
    import score_disp_pkg::*;
#(
    parameter int WIN_SCORE    = 5,
    parameter int BLINK_FRAMES = 32,
    parameter int BLINK_SHIFT  = 2
) (
    input logic                  myClk,
    input logic                  reset,
    score_scan_display_if.slave  disp
);

    localparam int         BW      = $clog2(BLINK_FRAMES + 1);
    localparam logic       WIN_EN  = (WIN_SCORE <= 7);
    localparam logic [2:0] WIN_THR = WIN_EN ? 3'(WIN_SCORE) : 3'd7;

    logic [1:0]    r_scanIdx;
    logic [2:0]    r_sh1, r_sh2;
    logic [BW-1:0] r_blink1, r_blink2;
    winner_e       r_winner;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;

    logic          w_sample;
    logic [BW-1:0] w_blink1Next, w_blink2Next;
    winner_e       w_winnerNext;
    logic          w_blank1, w_blank2;
    logic [3:0]    w_code, w_an;
    logic [6:0]    w_glyph;

    assign w_sample = (r_scanIdx == 2'd3);

    // Frame-sample results; only committed on the idx3 edge. A change reloads
    // the blink counter even on the edge it would otherwise expire.
    always_comb begin
        w_blink1Next = r_blink1;
        w_blink2Next = r_blink2;
        w_winnerNext = r_winner;
        if (disp.score1 != r_sh1)
            w_blink1Next = BW'(BLINK_FRAMES);
        else if (r_blink1 != '0)
            w_blink1Next = r_blink1 - BW'(1);
        if (disp.score2 != r_sh2)
            w_blink2Next = BW'(BLINK_FRAMES);
        else if (r_blink2 != '0)
            w_blink2Next = r_blink2 - BW'(1);
        if (r_winner == WIN_NONE) begin
            if (WIN_EN && (disp.score1 >= WIN_THR))
                w_winnerNext = WIN_P1;
            else if (WIN_EN && (disp.score2 >= WIN_THR))
                w_winnerNext = WIN_P2;
        end
    end

    // Digit 3 is driven on the sampling edge itself, so it shows the score
    // being captured on that edge together with its updated blink state.
    assign w_blank1 = (w_blink1Next != '0) && w_blink1Next[BLINK_SHIFT];
    assign w_blank2 = (r_blink2 != '0) && r_blink2[BLINK_SHIFT];

    always_comb begin
        w_an   = AN_OFF;
        w_code = CODE_BLANK;
        case (r_scanIdx)
            2'd0: begin
                w_an   = AN_D0;
                w_code = w_blank2 ? CODE_BLANK : {1'b0, r_sh2};
            end
            2'd1: begin
                w_an   = AN_D1;
                w_code = (r_winner == WIN_NONE) ? CODE_DASH :
                         (r_winner == WIN_P1)   ? 4'd1 : 4'd2;
            end
            2'd2: begin
                w_an   = AN_D2;
                w_code = (r_winner == WIN_NONE) ? CODE_DASH : CODE_P;
            end
            default: begin
                w_an   = AN_D3;
                w_code = w_blank1 ? CODE_BLANK : {1'b0, disp.score1};
            end
        endcase
    end

    seg7_glyph_rom u_rom (
        .i_code (w_code),
        .o_seg  (w_glyph)
    );

    always_ff @(posedge myClk) begin
        if (reset) begin
            r_scanIdx <= 2'd0;
            r_an      <= AN_OFF;
            r_seg     <= GLYPH_BLANK;
            r_winner  <= WIN_NONE;
            r_sh1     <= 3'd0;
            r_sh2     <= 3'd0;
            r_blink1  <= '0;
            r_blink2  <= '0;
        end else begin
            r_scanIdx <= r_scanIdx + 2'd1;
            r_an      <= w_an;
            r_seg     <= w_glyph;
            if (w_sample) begin
                r_sh1    <= disp.score1;
                r_sh2    <= disp.score2;
                r_blink1 <= w_blink1Next;
                r_blink2 <= w_blink2Next;
                r_winner <= w_winnerNext;
            end
        end
    end

    assign disp.seg    = r_seg;
    assign disp.an     = r_an;
    assign disp.winner = r_winner;

endmodule

// File: tb/tb_score_scan_display.sv
// Randomized, self-checking bench for score_scan_display against a
// frame-level behavioural model of the scoreboard display.
module tb_score_scan_display;

    localparam int WIN_SCORE    = 5;
    localparam int BLINK_FRAMES = 32;
    localparam int BLINK_SHIFT  = 2;

    localparam logic [6:0] G_DASH  = 7'b0111111;
    localparam logic [6:0] G_P     = 7'b0001100;
    localparam logic [6:0] G_BLANK = 7'b1111111;

    logic myClk;
    logic reset;
    score_scan_display_if bus ();

    score_scan_display #(
        .WIN_SCORE    (WIN_SCORE),
        .BLINK_FRAMES (BLINK_FRAMES),
        .BLINK_SHIFT  (BLINK_SHIFT)
    ) dut (
        .myClk (myClk),
        .reset (reset),
        .disp  (bus.slave)
    );

    initial myClk = 1'b0;
    always #5 myClk = ~myClk;

    int errors = 0;
    int checks = 0;

    // Behavioural model state: which digit the next edge drives, the scores
    // last captured per player, blink frames left per player, and the winner.
    int mIdx = 0;
    int mSh[2];
    int mBlink[2];
    int mWin = 0;
    logic [3:0] expAn;
    logic [6:0] expSeg;
    logic [1:0] expWin;

    logic [6:0] glyphTab [8];
    logic [3:0] anTab [4];
    logic [6:0] segTab [4];

    function automatic logic [6:0] shownDigit(int v, int b);
        if (b != 0 && ((b >> BLINK_SHIFT) % 2) == 1)
            return G_BLANK;
        return glyphTab[v];
    endfunction

    // Advance one clock: predict what the DUT does on the coming edge from the
    // inputs present now, then sample outputs 1 time unit after the edge.
    task automatic step();
        int s[2];
        s[0] = int'(bus.score1);
        s[1] = int'(bus.score2);
        if (reset) begin
            mIdx = 0; mSh[0] = 0; mSh[1] = 0; mBlink[0] = 0; mBlink[1] = 0; mWin = 0;
            expAn = 4'b1111; expSeg = G_BLANK;
        end else begin
            if (mIdx == 3) begin
                for (int p = 0; p < 2; p++) begin
                    if (s[p] != mSh[p]) mBlink[p] = BLINK_FRAMES;
                    else if (mBlink[p] > 0) mBlink[p] = mBlink[p] - 1;
                    mSh[p] = s[p];
                end
                if (mWin == 0) begin
                    if (s[0] >= WIN_SCORE) mWin = 1;
                    else if (s[1] >= WIN_SCORE) mWin = 2;
                end
            end
            expAn = ~(4'(1) << mIdx);
            case (mIdx)
                0: expSeg = shownDigit(mSh[1], mBlink[1]);
                1: expSeg = (mWin == 0) ? G_DASH : glyphTab[mWin];
                2: expSeg = (mWin == 0) ? G_DASH : G_P;
                default: expSeg = shownDigit(mSh[0], mBlink[0]);
            endcase
            mIdx = (mIdx + 1) % 4;
        end
        expWin = 2'(mWin);
        @(posedge myClk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input int s1, input int s2);
        reset = r;
        bus.score1 = 3'(s1);
        bus.score2 = 3'(s2);
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 3, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bus.an, bus.seg, bus.winner} !== {4'b1111, G_BLANK, 2'b00}) begin
                errors++;
                $display("[TB] FAIL reset: an/seg/win got %b/%b/%b want 1111/1111111/00",
                         bus.an, bus.seg, bus.winner);
            end
        end
    endtask

    task automatic test_scan();
        applyStimulus(1'b0, 3, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (bus.an !== anTab[i % 4]) begin
                errors++;
                $display("[TB] FAIL scan_an[%0d]: got %b want %b", i, bus.an, anTab[i % 4]);
            end
            if (i < 4 || (i % 4) != 3) begin
                checks++;
                if (bus.seg !== segTab[i % 4]) begin
                    errors++;
                    $display("[TB] FAIL scan_seg[%0d]: got %b want %b", i, bus.seg, segTab[i % 4]);
                end
            end
            checks++;
            if ({bus.an, bus.seg, bus.winner} !== {expAn, expSeg, expWin}) begin
                errors++;
                $display("[TB] FAIL scan_model[%0d]: got %b/%b/%b want %b/%b/%b",
                         i, bus.an, bus.seg, bus.winner, expAn, expSeg, expWin);
            end
        end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 8 && mIdx != 2; i++) step();
        checks++;
        if (mIdx != 2) begin
            errors++;
            $display("[TB] FAIL midframe_align: model index got %0d want 2", mIdx);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({bus.an, bus.seg, bus.winner} !== {4'b1111, G_BLANK, 2'b00}) begin
            errors++;
            $display("[TB] FAIL midframe_reset: got %b/%b/%b want 1111/1111111/00",
                     bus.an, bus.seg, bus.winner);
        end
        reset = 1'b0;
        step();
        checks++;
        if (bus.an !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL midframe_release_an: got %b want 1110", bus.an);
        end
    endtask

    task automatic test_blink();
        int blanks = 0;
        for (int i = 0; i < 8 && mIdx != 1; i++) step();
        bus.score2 = 3'd1;
        for (int i = 0; i < 160; i++) begin
            step();
            checks++;
            if ({bus.an, bus.seg, bus.winner} !== {expAn, expSeg, expWin}) begin
                errors++;
                $display("[TB] FAIL blink_model[%0d]: got %b/%b/%b want %b/%b/%b",
                         i, bus.an, bus.seg, bus.winner, expAn, expSeg, expWin);
            end
            if (bus.an == 4'b1110 && bus.seg == G_BLANK) blanks++;
            if (i >= 140 && bus.an == 4'b1110) begin
                checks++;
                if (bus.seg !== 7'b1111001) begin
                    errors++;
                    $display("[TB] FAIL blink_steady[%0d]: got %b want 1111001", i, bus.seg);
                end
            end
        end
        checks++;
        if (blanks == 0) begin
            errors++;
            $display("[TB] FAIL blink_seen: blank digit0 cycles got 0 want >0");
        end
    endtask

    task automatic test_winner();
        for (int i = 0; i < 8 && mIdx != 1; i++) step();
        bus.score1 = 3'd5;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if ({bus.an, bus.seg, bus.winner} !== {expAn, expSeg, expWin}) begin
                errors++;
                $display("[TB] FAIL winner_model[%0d]: got %b/%b/%b want %b/%b/%b",
                         i, bus.an, bus.seg, bus.winner, expAn, expSeg, expWin);
            end
            if (i >= 4 && bus.an == 4'b1101) begin
                checks++;
                if (bus.seg !== 7'b1111001) begin
                    errors++;
                    $display("[TB] FAIL winner_digit1: got %b want 1111001", bus.seg);
                end
            end
            if (i >= 4 && bus.an == 4'b1011) begin
                checks++;
                if (bus.seg !== 7'b0001100) begin
                    errors++;
                    $display("[TB] FAIL winner_digit2: got %b want 0001100", bus.seg);
                end
            end
        end
        checks++;
        if (bus.winner !== 2'b01) begin
            errors++;
            $display("[TB] FAIL winner_set: got %b want 01", bus.winner);
        end
        bus.score1 = 3'd0;
        for (int i = 0; i < 12; i++) step();
        checks++;
        if (bus.winner !== 2'b01) begin
            errors++;
            $display("[TB] FAIL winner_sticky: got %b want 01", bus.winner);
        end
    endtask

    task automatic test_both_cross();
        applyStimulus(1'b1, 4, 4);
        step();
        reset = 1'b0;
        for (int i = 0; i < 9; i++) step();
        bus.score1 = 3'd5;
        bus.score2 = 3'd5;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (bus.winner === 2'b10 || {bus.an, bus.seg, bus.winner} !== {expAn, expSeg, expWin}) begin
                errors++;
                $display("[TB] FAIL both_cross[%0d]: got %b/%b/%b want %b/%b/%b",
                         i, bus.an, bus.seg, bus.winner, expAn, expSeg, expWin);
            end
        end
        checks++;
        if (bus.winner !== 2'b01) begin
            errors++;
            $display("[TB] FAIL both_cross_final: got %b want 01", bus.winner);
        end
    endtask

    task automatic test_toggle();
        applyStimulus(1'b1, 2, 6);
        step();
        reset = 1'b0;
        for (int i = 0; i < 144; i++) step();
        for (int t = 0; t < 5; t++) begin
            bus.score1 = (bus.score1 == 3'd2) ? 3'd3 : 3'd2;
            for (int i = 0; i < 80; i++) begin
                step();
                checks++;
                if ({bus.an, bus.seg, bus.winner} !== {expAn, expSeg, expWin}) begin
                    errors++;
                    $display("[TB] FAIL toggle_model[%0d.%0d]: got %b/%b/%b want %b/%b/%b",
                             t, i, bus.an, bus.seg, bus.winner, expAn, expSeg, expWin);
                end
                if (bus.an == 4'b1110) begin
                    checks++;
                    if (bus.seg !== 7'b0000010) begin
                        errors++;
                        $display("[TB] FAIL toggle_p2_digit: got %b want 0000010", bus.seg);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        applyStimulus(1'b1, 0, 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(15) == 0) bus.score1 = 3'($urandom_range(7));
            if ($urandom_range(15) == 0) bus.score2 = 3'($urandom_range(7));
            reset = ($urandom_range(199) == 0);
            step();
            checks++;
            if ({bus.an, bus.seg, bus.winner} !== {expAn, expSeg, expWin}) begin
                errors++;
                $display("[TB] FAIL random_model[%0d]: got %b/%b/%b want %b/%b/%b",
                         i, bus.an, bus.seg, bus.winner, expAn, expSeg, expWin);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        glyphTab[0] = 7'b1000000; glyphTab[1] = 7'b1111001;
        glyphTab[2] = 7'b0100100; glyphTab[3] = 7'b0110000;
        glyphTab[4] = 7'b0011001; glyphTab[5] = 7'b0010010;
        glyphTab[6] = 7'b0000010; glyphTab[7] = 7'b1111000;
        anTab[0] = 4'b1110; anTab[1] = 4'b1101; anTab[2] = 4'b1011; anTab[3] = 4'b0111;
        segTab[0] = 7'b1000000; segTab[1] = G_DASH; segTab[2] = G_DASH; segTab[3] = 7'b0110000;
        mSh[0] = 0; mSh[1] = 0; mBlink[0] = 0; mBlink[1] = 0;
        applyStimulus(1'b1, 3, 0);

        test_reset();
        test_scan();
        test_reset_midframe();
        test_blink();
        test_winner();
        test_both_cross();
        test_toggle();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
